// File: rtl/te_pkg.sv
// ============================================================================
// Module  : te_pkg
// Brief   : Shared constants and types for the TE 3x3 window sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package te_pkg;

   localparam int TE_DATA_W = 8;

   // Tap positions inside the nine-tap window bus, in1 at the LSB end
   localparam int TAP_IN1 = 0;
   localparam int TAP_IN2 = 1;
   localparam int TAP_IN3 = 2;
   localparam int TAP_IN4 = 3;
   localparam int TAP_IN5 = 4;
   localparam int TAP_IN6 = 5;
   localparam int TAP_IN7 = 6;
   localparam int TAP_IN8 = 7;
   localparam int TAP_IN9 = 8;
   localparam int TE_NUM_TAPS = 9;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } te_win_state_t;

endpackage

`default_nettype wire

// File: rtl/te_line_buffer.sv
// ============================================================================
// Module  : te_line_buffer
// Brief   : One-line pixel store, single port, combinational read so the old
//           word is visible in the same cycle it is overwritten.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module te_line_buffer
   import te_pkg::*;
#(
   parameter int DEPTH  = 512,
   parameter int DATA_W = TE_DATA_W,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/te_window_sequencer.sv
// ============================================================================
// Module  : te_window_sequencer
// Brief   : Raster stream to 3x3 window sequencer for the TE filter bank.
//           Optional macro TE_WIN_STATS_EN adds the win_count output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module te_window_sequencer
   import te_pkg::*;
#(
   parameter int IMG_W  = 512,
   parameter int IMG_H  = 512,
   parameter int DATA_W = TE_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   in_pixel,
   input  logic                in_valid,
   input  logic                in_sof,
   output logic                in_ready,
   output logic [9*DATA_W-1:0] win_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_sof,
   output logic                out_eof,
   output logic                sof_err
`ifdef TE_WIN_STATS_EN
   ,
   output logic [31:0]         win_count
`endif
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   te_win_state_t state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [9*DATA_W-1:0] sr_q, sr_d;
   logic [9*DATA_W-1:0] win_data_q, win_data_d;
   logic out_valid_q, out_valid_d;
   logic out_sof_q, out_sof_d;
   logic out_eof_q, out_eof_d;
   logic sof_err_q, sof_err_d;

   logic take, accept, restart, process, emit;
   logic [COL_W-1:0] pos_col;
   logic [ROW_W-1:0] pos_row;
   logic [DATA_W-1:0] lb0_rd, lb1_rd;

   assign take     = out_valid_q && out_ready;
   assign in_ready = (state_q == IDLE) ? 1'b1 : (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign restart  = accept && in_sof;
   // Pixels seen in IDLE without a start marker are swallowed
   assign process  = accept && (in_sof || (state_q == ACTIVE));
   assign pos_col  = restart ? '0 : col_q;
   assign pos_row  = restart ? '0 : row_q;
   assign emit     = process && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);

   te_line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W),
      .ADDR_W (COL_W)
   ) u_lb0 (
      .clk     (clk),
      .we_i    (process),
      .addr_i  (pos_col),
      .wdata_i (in_pixel),
      .rdata_o (lb0_rd)
   );

   te_line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W),
      .ADDR_W (COL_W)
   ) u_lb1 (
      .clk     (clk),
      .we_i    (process),
      .addr_i  (pos_col),
      .wdata_i (lb0_rd),
      .rdata_o (lb1_rd)
   );

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      sr_d        = sr_q;
      win_data_d  = win_data_q;
      out_valid_d = out_valid_q;
      out_sof_d   = out_sof_q;
      out_eof_d   = out_eof_q;
      sof_err_d   = 1'b0;

      if (take) begin
         out_valid_d = 1'b0;
         out_sof_d   = 1'b0;
         out_eof_d   = 1'b0;
      end

      if (process) begin
         sr_d[TAP_IN1*DATA_W +: DATA_W] = sr_q[TAP_IN2*DATA_W +: DATA_W];
         sr_d[TAP_IN2*DATA_W +: DATA_W] = sr_q[TAP_IN3*DATA_W +: DATA_W];
         sr_d[TAP_IN3*DATA_W +: DATA_W] = lb1_rd;
         sr_d[TAP_IN4*DATA_W +: DATA_W] = sr_q[TAP_IN5*DATA_W +: DATA_W];
         sr_d[TAP_IN5*DATA_W +: DATA_W] = sr_q[TAP_IN6*DATA_W +: DATA_W];
         sr_d[TAP_IN6*DATA_W +: DATA_W] = lb0_rd;
         sr_d[TAP_IN7*DATA_W +: DATA_W] = sr_q[TAP_IN8*DATA_W +: DATA_W];
         sr_d[TAP_IN8*DATA_W +: DATA_W] = sr_q[TAP_IN9*DATA_W +: DATA_W];
         sr_d[TAP_IN9*DATA_W +: DATA_W] = in_pixel;

         sof_err_d = restart && (state_q == ACTIVE) &&
                     ((col_q != '0) || (row_q != '0));

         if (pos_col == COL_LAST) begin
            col_d = '0;
            if (pos_row == ROW_LAST) begin
               row_d   = '0;
               state_d = IDLE;
            end else begin
               row_d   = pos_row + 1'b1;
               state_d = ACTIVE;
            end
         end else begin
            col_d   = pos_col + 1'b1;
            row_d   = pos_row;
            state_d = ACTIVE;
         end
      end

      // Accept is blocked while a window is pending, so this never overwrites
      if (emit) begin
         win_data_d  = sr_d;
         out_valid_d = 1'b1;
         out_sof_d   = (pos_row == ROW_TWO) && (pos_col == COL_TWO);
         out_eof_d   = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         sr_q        <= '0;
         win_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         sof_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         sr_q        <= sr_d;
         win_data_q  <= win_data_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         sof_err_q   <= sof_err_d;
      end
   end

   assign win_data  = win_data_q;
   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign sof_err   = sof_err_q;

`ifdef TE_WIN_STATS_EN
   logic [31:0] win_count_q;

   // The start-of-frame window restarts the tally at one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_count_q <= 32'd0;
      end else if (take) begin
         win_count_q <= out_sof_q ? 32'd1 : (win_count_q + 32'd1);
      end
   end

   assign win_count = win_count_q;
`endif

endmodule

`default_nettype wire
